// File: rtl/display_port.sv
// display_port: CPU write port queued in a small FIFO.
// Each queued byte is held on digit_8 for a dwell period.
module display_port #(
  parameter logic [15:0] PORT_ADDR    = 16'hD010,
  parameter int          DEPTH        = 4,
  parameter int          DWELL_CYCLES = 50_000_000,
  parameter int          CNT_W        = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        we,
  output logic [7:0]  data_out,
  output logic [7:0]  digit_8,
  output logic        overflow,
  output logic [2:0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [15:0] STAT_ADDR = PORT_ADDR + 16'd1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [PW-1:0]    head_q, tail_q;
  logic [7:0]       mem [DEPTH];

  logic push_req, clr_req;
  logic full, empty;
  logic pop, push_ok, drop;

  assign push_req = we && (addr == PORT_ADDR);
  assign clr_req  = we && (addr == STAT_ADDR);
  assign full     = (fifo_count == 3'(DEPTH));
  assign empty    = (fifo_count == 3'd0);
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Display FSM: decides pops and next dwell timer value.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          timer_d = RELOAD;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (timer_q != '0) begin
          timer_d = timer_q - CNT_W'(1);
        end else if (!empty) begin
          pop     = 1'b1;
          timer_d = RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, timer and displayed byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      digit_8 <= 8'h00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      if (pop) digit_8 <= mem[head_q];
    end
  end

  // Queue pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      fifo_count <= 3'd0;
      overflow   <= 1'b0;
    end else begin
      if (pop)     head_q <= head_q + PW'(1);
      if (push_ok) tail_q <= tail_q + PW'(1);
      if (push_ok && !pop)      fifo_count <= fifo_count + 3'd1;
      else if (pop && !push_ok) fifo_count <= fifo_count - 3'd1;
      if (clr_req)   overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

  // Queue storage; contents are only read when occupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem[tail_q] <= data_in;
  end

  // Combinational read mux.
  always_comb begin
    data_out = 8'h00;
    if (addr == PORT_ADDR)
      data_out = digit_8;
    else if (addr == STAT_ADDR)
      data_out = {overflow, full, empty, 2'b00, fifo_count};
  end

endmodule
